// File: rtl/sonata_pkg.sv
// Shared switch-debounce defaults, per-bit FSM state encodings and a sizing helper.
// The top level and the software headers both take the switch defaults from here.
package sonata_pkg;

  // 5 joystick + 8 user + 3 selection switches.
  localparam int unsigned SwitchWidth         = 16;
  localparam int unsigned SwitchTickCycles    = 40_000;
  localparam int unsigned SwitchStableSamples = 4;

  localparam logic [0:0] DbStable  = 1'b0;
  localparam logic [0:0] DbPending = 1'b1;

  // The counter must be able to hold StableSamples-1.
  function automatic int unsigned db_cnt_w(input int unsigned samples);
    return $clog2(samples + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Per-switch debounce FSM: a new level is accepted only after StableSamples
// consecutive sample ticks disagree with the current debounced level.
module debounce_bit
  import sonata_pkg::*;
#(
  parameter int unsigned StableSamples = SwitchStableSamples
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic s_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);

  localparam int unsigned          CntW    = db_cnt_w(StableSamples);
  localparam logic [CntW-1:0]      LastCnt = CntW'(StableSamples - 1);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_cur;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // In STABLE the count is zero by definition, whatever the register holds.
  assign cnt_cur = (state_q == DbPending) ? cnt_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_cur;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (s_i != level_q) begin
        if (cnt_cur == LastCnt) begin
          level_d = s_i;
          cnt_d   = '0;
          state_d = DbStable;
          rise_d  = s_i;
          fall_d  = ~s_i;
        end else begin
          cnt_d   = cnt_cur + CntW'(1);
          state_d = DbPending;
        end
      end else begin
        cnt_d   = '0;
        state_d = DbStable;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DbStable;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign accept_o = rise_d | fall_d;

endmodule

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous inputs; both stages load ResetValue
// while the synchronous reset is high.
module prim_flop_2sync #(
  parameter int unsigned      Width      = 16,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/switch_debounce.sv
// Debounces Width active-low switch pins into active-high levels with
// one-cycle rise/fall pulses, sampling on a shared prescaled tick.
module switch_debounce
  import sonata_pkg::*;
#(
  parameter int unsigned Width         = SwitchWidth,
  parameter int unsigned TickCycles    = SwitchTickCycles,
  parameter int unsigned StableSamples = SwitchStableSamples
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] sw_ni,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  localparam int unsigned     PreW    = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TickCycles - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic             tick;
  logic [Width-1:0] sw_sync;
  logic [Width-1:0] s;
  logic [Width-1:0] accept;
  logic             changed_q, changed_d;

  // Pins idle high, so the synchroniser resets to "not pressed".
  prim_flop_2sync #(
    .Width      (Width),
    .ResetValue ({Width{1'b1}})
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sw_ni),
    .q_o   (sw_sync)
  );

  assign s = ~sw_sync;

  assign tick  = (pre_q == PreLast);
  assign pre_d = tick ? '0 : pre_q + PreW'(1);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    debounce_bit #(
      .StableSamples (StableSamples)
    ) u_bit (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick_i   (tick),
      .s_i      (s[i]),
      .level_o  (sw_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .accept_o (accept[i])
    );
  end

  // Registered from the same next-state terms as the per-bit pulses so they align.
  assign changed_d = |accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      changed_q <= changed_d;
    end
  end

  assign changed_o = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce (Width=4, TickCycles=4, StableSamples=3) with a
// cycle-level reference model built from the sampling and acceptance rules.
module tb_switch_debounce;

  localparam int W  = 4;
  localparam int TC = 4;
  localparam int SS = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_n = '1;
  logic [W-1:0] sw, rise, fall;
  logic         chg;

  int tests = 0;
  int fails = 0;

  switch_debounce #(
    .Width         (W),
    .TickCycles    (TC),
    .StableSamples (SS)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .sw_ni     (sw_n),
    .sw_o      (sw),
    .rise_o    (rise),
    .fall_o    (fall),
    .changed_o (chg)
  );

  always #5 clk = ~clk;

  // Reference model: pins seen two edges late, tick every TC edges after reset,
  // level flips after SS consecutive disagreeing ticks.
  logic [W-1:0] hist[$];
  int           cnt[W];
  int           n_edge;
  logic [W-1:0] e_sw, e_rise, e_fall;
  logic         e_chg;

  always @(posedge clk) begin
    logic [W-1:0] s;
    if (rst) begin
      hist   = '{'1, '1};
      n_edge = 0;
      for (int b = 0; b < W; b++) cnt[b] = 0;
      e_sw = '0; e_rise = '0; e_fall = '0; e_chg = 1'b0;
    end else begin
      s = ~hist.pop_front();
      hist.push_back(sw_n);
      e_rise = '0;
      e_fall = '0;
      if ((n_edge % TC) == TC - 1) begin
        for (int b = 0; b < W; b++) begin
          if (s[b] != e_sw[b]) begin
            cnt[b]++;
            if (cnt[b] == SS) begin
              e_sw[b]   = s[b];
              e_rise[b] = s[b];
              e_fall[b] = ~s[b];
              cnt[b]    = 0;
            end
          end else begin
            cnt[b] = 0;
          end
        end
      end
      n_edge++;
      e_chg = |(e_rise | e_fall);
    end
  end

  task automatic test_reset();
    repeat (5) begin
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== '0) begin
        fails++;
        $display("FAIL reset_hold got sw=%h r=%h f=%h c=%b want all zero", sw, rise, fall, chg);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== '0 || {sw, rise, fall, chg} !== {e_sw, e_rise, e_fall, e_chg}) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got sw=%h r=%h f=%h c=%b want zero", i, sw, rise, fall, chg);
      end
    end
  endtask

  task automatic test_press();
    int first = 0, nrise = 0, nchg = 0;
    sw_n[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== {e_sw, e_rise, e_fall, e_chg}) begin
        fails++;
        $display("FAIL press_model cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b",
                 i, sw, rise, fall, chg, e_sw, e_rise, e_fall, e_chg);
      end
      if (sw[0] && first == 0) first = i;
      nrise += int'(rise[0]);
      nchg  += int'(chg);
    end
    tests++;
    if (first < 1 || first > 15) begin
      fails++;
      $display("FAIL press_latency got %0d cycles want 1..15", first);
    end
    tests++;
    if (nrise != 1 || nchg != 1) begin
      fails++;
      $display("FAIL press_pulses got rise=%0d chg=%0d want 1/1", nrise, nchg);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    sw_n[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 6) sw_n[1] = 1'b1;
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== {e_sw, e_rise, e_fall, e_chg}) begin
        fails++;
        $display("FAIL glitch_model cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b",
                 i, sw, rise, fall, chg, e_sw, e_rise, e_fall, e_chg);
      end
      if (sw[1] || rise[1] || chg) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL glitch_leak got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_release();
    int nfall = 0;
    sw_n[0] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== {e_sw, e_rise, e_fall, e_chg}) begin
        fails++;
        $display("FAIL release_model cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b",
                 i, sw, rise, fall, chg, e_sw, e_rise, e_fall, e_chg);
      end
      nfall += int'(fall[0]);
    end
    tests++;
    if (nfall != 1 || sw[0] !== 1'b0) begin
      fails++;
      $display("FAIL release_fall got falls=%0d sw0=%b want 1 and 0", nfall, sw[0]);
    end
  endtask

  task automatic test_simultaneous();
    int nz = 0, nchg = 0;
    logic [W-1:0] seen = '0;
    logic         seen_chg = 1'b0;
    sw_n = 4'b0011;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== {e_sw, e_rise, e_fall, e_chg}) begin
        fails++;
        $display("FAIL simul_model cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b",
                 i, sw, rise, fall, chg, e_sw, e_rise, e_fall, e_chg);
      end
      if (rise != '0) begin nz++; seen = rise; seen_chg = chg; end
      nchg += int'(chg);
    end
    tests++;
    if (nz != 1 || seen !== 4'b1100 || seen_chg !== 1'b1 || nchg != 1) begin
      fails++;
      $display("FAIL simul_pulse got cycles=%0d rise=%b chg=%b nchg=%0d want 1/1100/1/1",
               nz, seen, seen_chg, nchg);
    end
  endtask

  task automatic test_reset_mid();
    int first = 0, nrise = 0, early = 0;
    sw_n = '1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== {e_sw, e_rise, e_fall, e_chg}) begin
        fails++;
        $display("FAIL rstmid_settle cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b",
                 i, sw, rise, fall, chg, e_sw, e_rise, e_fall, e_chg);
      end
    end
    sw_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== '0) begin
        fails++;
        $display("FAIL rstmid_abort got sw=%h r=%h f=%h c=%b want all zero", sw, rise, fall, chg);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== {e_sw, e_rise, e_fall, e_chg}) begin
        fails++;
        $display("FAIL rstmid_model cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b",
                 i, sw, rise, fall, chg, e_sw, e_rise, e_fall, e_chg);
      end
      if (sw[0] && first == 0) first = i;
      if (i < 12 && (sw[0] || rise[0])) early++;
      nrise += int'(rise[0]);
    end
    tests++;
    if (first != 12 || nrise != 1 || early != 0) begin
      fails++;
      $display("FAIL rstmid_redebounce got first=%0d rises=%0d early=%0d want 12/1/0",
               first, nrise, early);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        sw_n = W'($urandom_range(0, 15));
        hold = $urandom_range(1, 16);
      end
      hold--;
      @(negedge clk);
      tests++;
      if ({sw, rise, fall, chg} !== {e_sw, e_rise, e_fall, e_chg}) begin
        fails++;
        $display("FAIL random_model cyc=%0d got %h/%h/%h/%b want %h/%h/%h/%b",
                 i, sw, rise, fall, chg, e_sw, e_rise, e_fall, e_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter Width, default 16, is the number of switch bits (5 joystick + 8 user + 3 selection).
REQ-002 Parameter TickCycles, default 40_000, is the number of clk_i cycles per sample tick (1 ms at 40 MHz); legal range >= 1.
REQ-003 Parameter StableSamples, default 4, is the number of consecutive disagreeing ticks needed to accept a new level; legal range 1..15.
REQ-004 Port clk_i, input, 1 bit: the single clock; all logic runs on this clock, the system clock.
REQ-005 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port sw_ni, input, Width bits: raw switch pins; asynchronous; pulled up, so 0 means pressed.
REQ-007 Port sw_o, output, Width bits: debounced level, active-high (1 means pressed); feeds the GPIO inputs.
REQ-008 Port rise_o, output, Width bits: one-cycle pulse when a sw_o bit goes 0->1.
REQ-009 Port fall_o, output, Width bits: one-cycle pulse when a sw_o bit goes 1->0.
REQ-010 Port changed_o, output, 1 bit: OR-reduction of rise_o | fall_o, registered in the same cycle as those pulses.

Function
REQ-011 Each sw_ni bit SHALL pass through a two-flop synchroniser; the synchronised value is inverted to give the active-high level s.
REQ-012 A free-running prescaler SHALL count 0..TickCycles-1 and assert a one-cycle tick when it is at TickCycles-1, then wrap to 0; with TickCycles=1, tick is asserted every cycle.
REQ-013 Each bit SHALL use a two-state FSM: STABLE (s == sw_o, counter 0) and PENDING (s != sw_o, counter counting).
REQ-014 On a tick with s != sw_o: if counter+1 == StableSamples, then sw_o <= s, counter <= 0, the state returns to STABLE and the matching rise_o/fall_o bit pulses; otherwise counter increments and the state is PENDING.
REQ-015 On a tick with s == sw_o, the counter SHALL clear to 0 and the state SHALL become STABLE; a glitch shorter than StableSamples ticks never reaches sw_o.
REQ-016 On non-tick cycles, the counter, state and sw_o SHALL hold.
REQ-017 rise_o, fall_o and changed_o SHALL be high for exactly the cycle after the accepting tick (registered together with sw_o), and low otherwise.
REQ-018 Bits SHALL be fully independent; simultaneous transitions on several bits produce simultaneous pulses.
REQ-019 Worst-case latency from a pin edge to sw_o is 2 + StableSamples*TickCycles + 1 cycles; the best case is 2 + (StableSamples-1)*TickCycles + 1 cycles.
REQ-020 The counter SHALL be $clog2(StableSamples+1) bits wide and SHALL never exceed StableSamples-1.

Reset
REQ-021 While rst_i is high, the synchroniser flops SHALL load all-ones (not pressed).
REQ-022 While rst_i is high, the prescaler and all counters SHALL load 0, every FSM SHALL be STABLE, and sw_o, rise_o, fall_o and changed_o SHALL be 0.
REQ-023 Reset asserted in mid-debounce SHALL abort all pending transitions with no pulses; after release, a switch already held pressed is reported via a normal rise_o after full debounce.

Structure
REQ-024 The default Width, TickCycles and StableSamples values SHALL be localparams in sonata_pkg so the top level and software headers agree.
REQ-025 One sub-module, debounce_bit (per-bit FSM and counter), SHALL be instantiated Width times.
REQ-026 The prescaler and the synchroniser SHALL be shared in the parent; the synchroniser SHALL use the existing prim flop-2-sync cell.

Verification (bench uses Width=4, TickCycles=4, StableSamples=3)
REQ-027 Reset release with sw_ni=4'hF -> sw_o=0, no pulses for 100 cycles.
REQ-028 Drive sw_ni[0]=0 and hold -> sw_o[0]=1 within 2+12+1=15 cycles, with exactly one rise_o[0] and changed_o pulse.
REQ-029 Drive sw_ni[1]=0 for 6 cycles, then release -> sw_o[1] stays 0 and no pulse occurs.
REQ-030 With sw_o[0]=1, drive sw_ni[0]=1 -> after debounce, one fall_o[0] pulse and sw_o[0]=0.
REQ-031 Press bits 2 and 3 in the same cycle -> rise_o=4'b1100 in a single cycle and changed_o=1 for one cycle.
REQ-032 Assert rst_i two ticks into a pending press -> no pulses; after release, sw_o[0] rises only after a full 3-tick debounce.
